// File: rtl/debug_view_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_view_pkg
//  Description : Shared view codes, LED encodings, mode enum and small
//                helpers for the front-panel debug view sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_view_pkg;

    // View codes understood by the debug display mux
    localparam logic [2:0] VIEW_RDATA1 = 3'd0;
    localparam logic [2:0] VIEW_RDATA2 = 3'd1;
    localparam logic [2:0] VIEW_RESULT = 3'd2;
    localparam logic [2:0] VIEW_WDATA  = 3'd3;
    localparam logic [2:0] VIEW_NEXTPC = 3'd4;

    localparam int         NUM_VIEWS   = 5;
    localparam logic [4:0] LED_INVALID = 5'b11111;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    // One-hot indicator for a valid view; all LEDs lit for codes 5..7
    function automatic logic [4:0] view_led(input logic [2:0] sel);
        logic [4:0] led;
        if (sel < 3'(NUM_VIEWS)) begin
            led = 5'b00001 << sel;
        end else begin
            led = LED_INVALID;
        end
        return led;
    endfunction

    // Auto-scan order Rdata1 -> Rdata2 -> Result -> Wdata -> nextPC -> Rdata1
    function automatic logic [2:0] next_view(input logic [2:0] sel);
        logic [2:0] nxt;
        if (sel == VIEW_NEXTPC) begin
            nxt = VIEW_RDATA1;
        end else begin
            nxt = sel + 3'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_view_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_view_sequencer_if
//  Description : Front-panel bundle: raw keys and switches in, view select,
//                view LEDs, step enable, mode flag and step count out.
//                master = sequencer side, slave = panel/display side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_view_sequencer_if #(
    parameter int STEP_CNT_W = 16
);
    logic                  KEY_STEP_n;  // raw step button, active-low
    logic                  KEY_MODE_n;  // raw mode button, active-low
    logic [2:0]            SW_SEL;      // raw view-select switches
    logic [2:0]            SEL;         // registered view code
    logic [4:0]            SEL_LED;     // one-hot view indicator
    logic                  STEP;        // one-cycle CPU clock enable
    logic                  AUTO;        // auto-scan mode active
    logic [STEP_CNT_W-1:0] STEP_CNT;    // issued step pulses (wrapping)

    modport master (
        input  KEY_STEP_n, KEY_MODE_n, SW_SEL,
        output SEL, SEL_LED, STEP, AUTO, STEP_CNT
    );

    modport slave (
        output KEY_STEP_n, KEY_MODE_n, SW_SEL,
        input  SEL, SEL_LED, STEP, AUTO, STEP_CNT
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : 2-flop synchroniser, stable-level counter and press pulse
//                for one active-low push-button.
//  Ports       : CLK, RST      - clock, async active-high reset
//                i_key_n       - raw button level (asynchronous)
//                o_press       - one-cycle pulse on an accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic i_key_n,
    output logic      o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;

    // Synchroniser and debounced level start "released" so a key held
    // through reset is seen as a fresh press once reset drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= ~r_sync[1];  // only the 1->0 flip is a press
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/debug_view_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_view_sequencer
//  Description : Front-panel controller for the MIPS debug path. Debounces
//                the step and mode keys, issues single-cycle step enables,
//                and selects the debug view either from the switches
//                (manual) or from a dwell-timed scan (auto).
//  Ports       : CLK, RST  - clock, async active-high reset
//                panel     - keys/switches in; SEL, SEL_LED, STEP, AUTO,
//                            STEP_CNT out
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_view_sequencer
    import debug_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 50000000,
    parameter int STEP_CNT_W      = 16
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    debug_view_sequencer_if.master  panel
);

    localparam int c_DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);

    logic                  w_step_press;
    logic                  w_mode_press;
    logic [2:0]            r_sw_sync0;
    logic [2:0]            r_sw_sync1;
    mode_t                 r_mode;
    mode_t                 w_mode_nxt;
    logic [2:0]            r_sel;
    logic [2:0]            w_sel_nxt;
    logic [4:0]            r_sel_led;
    logic [c_DWELL_W-1:0]  r_dwell;
    logic [c_DWELL_W-1:0]  w_dwell_nxt;
    logic                  r_step;
    logic [STEP_CNT_W-1:0] r_step_cnt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .CLK     (CLK),
        .RST     (RST),
        .i_key_n (panel.KEY_STEP_n),
        .o_press (w_step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .CLK     (CLK),
        .RST     (RST),
        .i_key_n (panel.KEY_MODE_n),
        .o_press (w_mode_press)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sw_sync0 <= '0;
            r_sw_sync1 <= '0;
            r_mode     <= MANUAL;
            r_sel      <= VIEW_RDATA1;
            r_sel_led  <= 5'b00001;
            r_dwell    <= '0;
            r_step     <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_sw_sync0 <= panel.SW_SEL;
            r_sw_sync1 <= r_sw_sync0;
            r_mode     <= w_mode_nxt;
            r_sel      <= w_sel_nxt;
            // LEDs decode the next SEL so both registers change together
            r_sel_led  <= view_led(w_sel_nxt);
            r_dwell    <= w_dwell_nxt;
            r_step     <= w_step_press;
            if (w_step_press) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    // Mode toggles first; the resulting mode then decides where SEL goes,
    // so a simultaneous step press never overrides a mode change.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_sel_nxt   = r_sel;
        w_dwell_nxt = r_dwell;

        if (w_mode_press) begin
            w_mode_nxt = (r_mode == MANUAL) ? AUTO : MANUAL;
        end

        if (w_mode_nxt == MANUAL) begin
            w_sel_nxt   = r_sw_sync1;
            w_dwell_nxt = '0;
        end else if (w_mode_press || w_step_press) begin
            // Entering auto or stepping restarts the scan at Rdata1;
            // this also wins over a coincident dwell terminal count.
            w_sel_nxt   = VIEW_RDATA1;
            w_dwell_nxt = '0;
        end else if (r_dwell == c_DWELL_LAST) begin
            w_sel_nxt   = next_view(r_sel);
            w_dwell_nxt = '0;
        end else begin
            w_dwell_nxt = r_dwell + 1'b1;
        end
    end

    assign panel.SEL      = r_sel;
    assign panel.SEL_LED  = r_sel_led;
    assign panel.STEP     = r_step;
    assign panel.AUTO     = (r_mode == AUTO);
    assign panel.STEP_CNT = r_step_cnt;

endmodule
`default_nettype wire

// File: doc/debug_view_sequencer.md
Name: debug_view_sequencer

Overview:
Front-panel controller for the DE10-Lite single-clock MIPS debug path. It debounces the two push-buttons and issues single-cycle CPU step enables. It also drives the 3-bit view-select code and one-hot view LEDs consumed by the debug display mux. It has a manual mode, where the view follows the switches, and an auto-scan mode, where it cycles Rdata1 → Rdata2 → Result → Wdata → nextPC on a dwell timer.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level (10 ms at 50 MHz)
DWELL_CYCLES, 50000000, cycles each view is held in auto mode (1 s at 50 MHz)
STEP_CNT_W, 16, width of the step counter

Ports:
CLK  input  1  system clock (50 MHz board clock)
RST  input  1  asynchronous, active-high reset
KEY_STEP_n  input  1  raw step button, active-low, asynchronous to CLK
KEY_MODE_n  input  1  raw mode button, active-low, asynchronous to CLK
SW_SEL  input  3  raw view-select switches, used in manual mode
SEL  output  3  registered view code to the display mux
SEL_LED  output  5  registered one-hot view indicator; 11111 = invalid code
STEP  output  1  one-cycle CPU clock-enable pulse per accepted step press
AUTO  output  1  1 = auto-scan mode active
STEP_CNT  output  STEP_CNT_W  number of STEP pulses issued, modulo 2^STEP_CNT_W

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high. All flops clear on RST assertion; state is held while RST is high.
- Reset values: SEL=000, SEL_LED=00001, STEP=0, AUTO=0, STEP_CNT=0, dwell counter=0. Debounced key levels reset to 1 (released).
- Synchronisation: each key and SW_SEL passes through a 2-flop synchroniser.
- Debounce:
  - A synchronised key level differing from the debounced level starts a counter.
  - The counter clears whenever the input returns to the debounced level.
  - After DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips.
  - A 1→0 flip (press) yields a one-cycle press pulse. A release yields no pulse.
  - A key held through reset produces one press, DEBOUNCE_CYCLES+2 cycles after RST falls.
- STEP: registered copy of the step press pulse. It is high for exactly one cycle per accepted press and is never asserted two cycles in a row. STEP_CNT increments in the same cycle STEP is high and wraps from all-ones to 0.
- Mode FSM, states MANUAL and AUTO:
  - Mode press in MANUAL → AUTO: SEL=000, dwell counter=0, AUTO=1, all in the next cycle.
  - Mode press in AUTO → MANUAL: AUTO=0; SEL follows the synchronised SW_SEL starting the next cycle.
- MANUAL: SEL = synchronised SW_SEL, registered (total latency 3 cycles from the pin). SEL_LED:
  - codes 0..4 → one-hot with bit[SEL] set;
  - codes 5..7 → 11111, with SEL still carrying the raw code.
- AUTO dwell counter:
  - Counts 0..DWELL_CYCLES-1.
  - At terminal count it wraps to 0 and SEL advances 0→1→2→3→4→0.
  - SEL never takes 5..7 in AUTO.
- Step press in AUTO: STEP fires as in manual mode; SEL=000 and dwell counter=0 next cycle, so the scan restarts from Rdata1 after each instruction.
- Simultaneous events:
  - Step press and mode press in the same cycle: STEP fires and the mode toggles. The mode action decides SEL: entering AUTO → 0; entering MANUAL → switches.
  - Step press coinciding with dwell terminal count: the step reset wins and SEL=0.
- SEL_LED is always derived from the next-state SEL, so it is in the same cycle as SEL.

Decomposition:
- Package debug_view_pkg:
  - view code constants VIEW_RDATA1=0, VIEW_RDATA2=1, VIEW_RESULT=2, VIEW_WDATA=3, VIEW_NEXTPC=4;
  - NUM_VIEWS=5;
  - LED_INVALID=5'b11111;
  - mode enum {MANUAL, AUTO}.
- Sub-module key_debounce, instantiated twice: 2-flop synchroniser + stable counter + press pulse, parameterised by DEBOUNCE_CYCLES.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, DWELL_CYCLES=8, STEP_CNT_W=4; keys driven in cycles.
1. Reset: assert RST mid-run with AUTO=1 and SEL=3 → immediately SEL=0, SEL_LED=00001, AUTO=0, STEP=0, STEP_CNT=0.
2. Bounce: KEY_STEP_n low 2 cycles, high 1, low 10, high → exactly one STEP pulse, 1 cycle wide; STEP_CNT=1; no pulse on release.
3. Manual: SW_SEL=3 → SEL=3, SEL_LED=01000 after 3 cycles; SW_SEL=6 → SEL=6, SEL_LED=11111.
4. Auto scan: mode press → AUTO=1, SEL=0. Then SEL=1 after 8 cycles, 2 after 16, 4 after 32, back to 0 after 40. Second mode press → SEL equals SW_SEL.
5. Step in AUTO at SEL=3, dwell count 5 → STEP pulse, SEL=0 next cycle, SEL=1 exactly 8 cycles later. A step press timed at dwell terminal count → SEL=0, not 4.
6. Wrap: 16 clean step presses → STEP_CNT goes 15 then 0; 16 STEP pulses total.
